// File: rtl/dsp_pkg.sv
// Shared constants and types for the DSP program sequencer: opcodes, ALU and mux encodings, FSM state.
// The optional interrupt state exists only when DSP_SEQ_INT_EN is defined.
package dsp_pkg;

  // Opcode lives in instr[15:12]; unlisted values (4'hC..4'hE) execute as NOP.
  localparam logic [3:0] OP_LAC  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SACL = 4'h3;
  localparam logic [3:0] OP_LT   = 4'h4;
  localparam logic [3:0] OP_MPY  = 4'h5;
  localparam logic [3:0] OP_PAC  = 4'h6;
  localparam logic [3:0] OP_APAC = 4'h7;
  localparam logic [3:0] OP_ZAC  = 4'h8;
  localparam logic [3:0] OP_B    = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  localparam logic [1:0] ALU_IN_MEM = 2'd0;
  localparam logic [1:0] ALU_IN_P   = 2'd1;

  localparam logic [2:0] ACC_ALU  = 3'd0;
  localparam logic [2:0] ACC_MEM  = 3'd1;
  localparam logic [2:0] ACC_P    = 3'd2;
  localparam logic [2:0] ACC_ZERO = 3'd4;

  localparam logic [1:0] PC_TARGET = 2'd0;
  localparam logic [1:0] PC_INC    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_BR2,
    ST_HALTED
`ifdef DSP_SEQ_INT_EN
    , ST_INT
`endif
  } state_e;

  typedef enum logic [1:0] {
    CLS_OP,
    CLS_B,
    CLS_BZ,
    CLS_HALT
  } instr_class_e;

  typedef struct packed {
    logic       accum_ld;
    logic       t_ld;
    logic       p_ld;
    logic       data_we;
    logic [2:0] alu_ctrl;
    logic [1:0] alu_in_sel;
    logic [2:0] accum_in_sel;
  } ctrl_t;

endpackage

// File: rtl/dsp_seq_decode.sv
// Combinational opcode decode: instruction class plus the datapath control bundle for EXEC.
module dsp_seq_decode
  import dsp_pkg::*;
(
  input  logic [3:0]   opcode,
  output instr_class_e cls,
  output ctrl_t        ctrl
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    cls  = CLS_OP;
    ctrl = '0;
    case (opcode)
      OP_LAC: begin
        ctrl.accum_ld     = 1'b1;
        ctrl.accum_in_sel = ACC_MEM;
      end
      OP_ADD, OP_SUB: begin
        ctrl.accum_ld     = 1'b1;
        ctrl.accum_in_sel = ACC_ALU;
        ctrl.alu_in_sel   = ALU_IN_MEM;
        ctrl.alu_ctrl     = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
      end
      OP_SACL: ctrl.data_we = 1'b1;
      OP_LT:   ctrl.t_ld    = 1'b1;
      OP_MPY:  ctrl.p_ld    = 1'b1;
      OP_PAC: begin
        ctrl.accum_ld     = 1'b1;
        ctrl.accum_in_sel = ACC_P;
      end
      OP_APAC: begin
        ctrl.accum_ld     = 1'b1;
        ctrl.accum_in_sel = ACC_ALU;
        ctrl.alu_in_sel   = ALU_IN_P;
        ctrl.alu_ctrl     = ALU_ADD;
      end
      OP_ZAC: begin
        ctrl.accum_ld     = 1'b1;
        ctrl.accum_in_sel = ACC_ZERO;
      end
      OP_B:    cls = CLS_B;
      OP_BZ:   cls = CLS_BZ;
      OP_HALT: cls = CLS_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/dsp_sequencer.sv
// Fetch/execute control FSM for a small accumulator DSP: drives PC, datapath enables and a retired count.
// Define DSP_SEQ_INT_EN to add the irq/int_ack interrupt entry (vector 12'h002 supplied by the datapath).
module dsp_sequencer
  import dsp_pkg::*;
#(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic             acc_zero,
`ifdef DSP_SEQ_INT_EN
  input  logic             irq,
  output logic             int_ack,
`endif
  output logic             pc_ld,
  output logic [1:0]       pc_sel,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       alu_in_sel,
  output logic [2:0]       accum_in_sel,
  output logic             accum_ld,
  output logic             t_ld,
  output logic             p_ld,
  output logic             data_we,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  // Branch targets come from a 12-bit field, so the PC must be at least that wide.
  if (PC_W < 12) begin : g_pc_w_check
    $error("dsp_sequencer: PC_W must be >= 12");
  end

  state_e             state_q, state_d;
  logic               br_taken_q, br_taken_d;
  logic [CNT_W-1:0]   retired_q;
  logic               retire;
  instr_class_e       dec_cls;
  ctrl_t              dec_ctrl;
  ctrl_t              ctrl;
  logic               unused_operand;

  assign unused_operand = ^instr[11:0];

  dsp_seq_decode u_decode (
    .opcode (instr[15:12]),
    .cls    (dec_cls),
    .ctrl   (dec_ctrl)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      br_taken_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      br_taken_q <= br_taken_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    br_taken_d = br_taken_q;
    retire     = 1'b0;
    ctrl       = '0;
    pc_ld      = 1'b0;
    pc_sel     = PC_TARGET;
`ifdef DSP_SEQ_INT_EN
    int_ack    = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_HALTED: if (start) state_d = ST_FETCH;
      ST_FETCH:           state_d = ST_EXEC;
      ST_EXEC: begin
        case (dec_cls)
          CLS_OP: begin
            ctrl    = dec_ctrl;
            pc_ld   = 1'b1;
            pc_sel  = PC_INC;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_B, CLS_BZ: begin
            // Step over the opcode word; BR2 then sees the target word on instr.
            pc_ld      = 1'b1;
            pc_sel     = PC_INC;
            br_taken_d = (dec_cls == CLS_B) || acc_zero;
            state_d    = ST_BR2;
          end
          default: begin
            retire  = 1'b1;
            state_d = ST_HALTED;
          end
        endcase
      end
      ST_BR2: begin
        pc_ld   = 1'b1;
        pc_sel  = br_taken_q ? PC_TARGET : PC_INC;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
`ifdef DSP_SEQ_INT_EN
      ST_INT: begin
        pc_ld   = 1'b1;
        pc_sel  = PC_TARGET;
        int_ack = 1'b1;
        state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef DSP_SEQ_INT_EN
    if (irq && (state_q == ST_EXEC || state_q == ST_BR2)) state_d = ST_INT;
`endif
  end

  assign accum_ld     = ctrl.accum_ld;
  assign t_ld         = ctrl.t_ld;
  assign p_ld         = ctrl.p_ld;
  assign data_we      = ctrl.data_we;
  assign alu_ctrl     = ctrl.alu_ctrl;
  assign alu_in_sel   = ctrl.alu_in_sel;
  assign accum_in_sel = ctrl.accum_in_sel;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted       = (state_q == ST_HALTED);
  assign retired      = retired_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed self-checking bench for dsp_sequencer: decode classes, branches, HALT and reset abort.
module tb_dsp_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, acc_zero;
  logic [15:0] instr;
  logic        pc_ld, accum_ld, t_ld, p_ld, data_we, busy, halted;
  logic [1:0]  pc_sel, alu_in_sel;
  logic [2:0]  alu_ctrl, accum_in_sel;
  logic [15:0] retired;
`ifdef DSP_SEQ_INT_EN
  logic        irq = 1'b0;
  logic        int_ack;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] E_NONE = 4'b0000, E_ACC = 4'b1000, E_T = 4'b0100,
                         E_P = 4'b0010, E_WE = 4'b0001;
  localparam logic [15:0] I_NOP = 16'hF000, I_LAC = 16'h0010, I_ADD = 16'h1011,
                          I_SACL = 16'h3012, I_B = 16'h9000, I_BZ = 16'hA000,
                          I_HALT = 16'hB000, I_TGT = 16'h0040;

  dsp_sequencer #(.PC_W(12), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .instr        (instr),
    .acc_zero     (acc_zero),
`ifdef DSP_SEQ_INT_EN
    .irq          (irq),
    .int_ack      (int_ack),
`endif
    .pc_ld        (pc_ld),
    .pc_sel       (pc_sel),
    .alu_ctrl     (alu_ctrl),
    .alu_in_sel   (alu_in_sel),
    .accum_in_sel (accum_in_sel),
    .accum_ld     (accum_ld),
    .t_ld         (t_ld),
    .p_ld         (p_ld),
    .data_we      (data_we),
    .busy         (busy),
    .halted       (halted),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {pc_ld, pc_sel, alu_ctrl, alu_in_sel, accum_in_sel, en[4], busy, halted}.
  function automatic logic [16:0] outs();
    return {pc_ld, pc_sel, alu_ctrl, alu_in_sel, accum_in_sel,
            accum_ld, t_ld, p_ld, data_we, busy, halted};
  endfunction

  function automatic logic [16:0] ov(input logic pl, input logic [1:0] ps,
                                     input logic [2:0] ac, input logic [1:0] ais,
                                     input logic [2:0] accs, input logic [3:0] en,
                                     input logic b, input logic h);
    return {pl, ps, ac, ais, accs, en, b, h};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then drive the inputs for the new cycle and let outputs settle.
  task automatic step(input logic [15:0] ins, input logic az, input logic st);
    @(posedge clk);
    #2;
    instr    = ins;
    acc_zero = az;
    start    = st;
    #1;
  endtask

  logic [15:0] tab_i [8];
  logic [16:0] tab_e [8];
  logic        seen;

  initial begin
    reset = 1'b1; start = 1'b0; acc_zero = 1'b0; instr = I_NOP;
    #3;
    check("reset_outs", 32'(outs()), 32'(ov(0, 0, 0, 0, 0, E_NONE, 0, 0)));
    check("reset_retired", 32'(retired), 32'd0);
    step(I_NOP, 0, 0);
    step(I_NOP, 0, 0);
    reset = 1'b0;

    step(I_NOP, 0, 1);
    check("idle", 32'(outs()), 32'(ov(0, 0, 0, 0, 0, E_NONE, 0, 0)));
    step(I_NOP, 0, 0);
    check("fetch", 32'(outs()), 32'(ov(0, 0, 0, 0, 0, E_NONE, 1, 0)));
    step(I_LAC, 0, 0);
    check("exec_lac", 32'(outs()), 32'(ov(1, 3, 0, 0, 1, E_ACC, 1, 0)));
    step(I_NOP, 0, 0);
    step(I_ADD, 0, 0);
    check("exec_add", 32'(outs()), 32'(ov(1, 3, 1, 0, 0, E_ACC, 1, 0)));
    step(I_NOP, 0, 0);
    step(I_SACL, 0, 0);
    check("exec_sacl", 32'(outs()), 32'(ov(1, 3, 0, 0, 0, E_WE, 1, 0)));
    step(I_NOP, 0, 0);
    check("retired_3", 32'(retired), 32'd3);

    tab_i[0] = 16'h2005; tab_e[0] = ov(1, 3, 2, 0, 0, E_ACC, 1, 0);  // SUB
    tab_i[1] = 16'h4006; tab_e[1] = ov(1, 3, 0, 0, 0, E_T,   1, 0);  // LT
    tab_i[2] = 16'h5007; tab_e[2] = ov(1, 3, 0, 0, 0, E_P,   1, 0);  // MPY
    tab_i[3] = 16'h6000; tab_e[3] = ov(1, 3, 0, 0, 2, E_ACC, 1, 0);  // PAC
    tab_i[4] = 16'h7000; tab_e[4] = ov(1, 3, 1, 1, 0, E_ACC, 1, 0);  // APAC
    tab_i[5] = 16'h8000; tab_e[5] = ov(1, 3, 0, 0, 4, E_ACC, 1, 0);  // ZAC
    tab_i[6] = I_NOP;    tab_e[6] = ov(1, 3, 0, 0, 0, E_NONE, 1, 0); // NOP
    tab_i[7] = 16'hC123; tab_e[7] = ov(1, 3, 0, 0, 0, E_NONE, 1, 0); // unknown -> NOP
    for (int i = 0; i < 8; i++) begin
      step(tab_i[i], 0, 0);
      check($sformatf("exec_tab%0d", i), 32'(outs()), 32'(tab_e[i]));
      step(I_NOP, 0, 0);
    end
    check("retired_11", 32'(retired), 32'd11);

    // BZ taken; acc_zero flips low in BR2 and must not matter.
    step(I_BZ, 1, 0);
    check("bz1_exec", 32'(outs()), 32'(ov(1, 3, 0, 0, 0, E_NONE, 1, 0)));
    step(I_TGT, 0, 0);
    check("bz1_br2", 32'(outs()), 32'(ov(1, 0, 0, 0, 0, E_NONE, 1, 0)));
    check("bz1_retired_br2", 32'(retired), 32'd11);
    step(I_NOP, 0, 0);
    check("bz1_retired", 32'(retired), 32'd12);

    step(I_B, 0, 0);
    step(I_TGT, 1, 0);
    check("b_br2", 32'(outs()), 32'(ov(1, 0, 0, 0, 0, E_NONE, 1, 0)));
    step(I_NOP, 0, 0);

    // BZ not taken; acc_zero rises in BR2 and must not matter.
    step(I_BZ, 0, 0);
    check("bz0_exec", 32'(outs()), 32'(ov(1, 3, 0, 0, 0, E_NONE, 1, 0)));
    step(I_TGT, 1, 0);
    check("bz0_br2", 32'(outs()), 32'(ov(1, 3, 0, 0, 0, E_NONE, 1, 0)));
    step(I_NOP, 0, 0);
    check("bz0_retired", 32'(retired), 32'd14);

    // HALT with start held high in EXEC: start is ignored while busy.
    step(I_HALT, 0, 1);
    check("halt_exec", 32'(outs()), 32'(ov(0, 0, 0, 0, 0, E_NONE, 1, 0)));
    step(I_NOP, 0, 0);
    check("halted", 32'(outs()), 32'(ov(0, 0, 0, 0, 0, E_NONE, 0, 1)));
    check("halt_retired", 32'(retired), 32'd15);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(I_NOP, 0, 0);
      seen |= pc_ld | busy | ~halted;
    end
    check("halt_hold", 32'(seen), 32'd0);
    step(I_NOP, 0, 1);
    step(I_NOP, 0, 0);
    check("resume_fetch", 32'(outs()), 32'(ov(0, 0, 0, 0, 0, E_NONE, 1, 0)));
    step(I_LAC, 0, 0);
    check("resume_lac", 32'(outs()), 32'(ov(1, 3, 0, 0, 1, E_ACC, 1, 0)));
    step(I_NOP, 0, 0);
    check("resume_retired", 32'(retired), 32'd16);

    // Reset pulsed in BR2 abandons the branch.
    step(I_B, 0, 0);
    step(I_TGT, 0, 0);
    check("pre_reset_br2", 32'(outs()), 32'(ov(1, 0, 0, 0, 0, E_NONE, 1, 0)));
    reset = 1'b1;
    #1;
    check("reset_br2_outs", 32'(outs()), 32'(ov(0, 0, 0, 0, 0, E_NONE, 0, 0)));
    check("reset_br2_retired", 32'(retired), 32'd0);
    step(I_NOP, 0, 0);
    step(I_NOP, 0, 0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(I_TGT, 0, 0);
      seen |= pc_ld | data_we | busy;
    end
    check("post_reset_quiet", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
